// File: rtl/icache_pkg.sv
// Shared definitions for the direct-mapped instruction cache.
package icache_pkg;

  typedef enum logic {
    ICACHE_IDLE   = 1'b0,
    ICACHE_REFILL = 1'b1
  } icache_state_e;

  localparam int DEF_INDEX_BITS = 6;
  localparam int DEF_ADDR_BITS  = 18;

endpackage

// File: rtl/icache_array.sv
// Valid/tag/data storage for the instruction cache: one write port, combinational read and hit compare.
module icache_array
  import icache_pkg::*;
#(
  parameter int INDEX_BITS = DEF_INDEX_BITS,
  parameter int TAG_BITS   = DEF_ADDR_BITS - DEF_INDEX_BITS - 2
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  i_wr_en,
  input  logic [INDEX_BITS-1:0] i_wr_idx,
  input  logic [TAG_BITS-1:0]   i_wr_tag,
  input  logic [31:0]           i_wr_data,
  input  logic [INDEX_BITS-1:0] i_rd_idx,
  input  logic [TAG_BITS-1:0]   i_rd_tag,
  output logic                  o_rd_hit,
  output logic [31:0]           o_rd_data
);

  localparam int LINES = 1 << INDEX_BITS;

  logic [LINES-1:0]    r_valid;
  logic [TAG_BITS-1:0] r_tag  [LINES];
  logic [31:0]         r_data [LINES];

  // Only the valid bits need reset; stale tag/data are masked by valid.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_valid <= '0;
    end else if (i_wr_en) begin
      r_valid[i_wr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (i_wr_en) begin
      r_tag[i_wr_idx]  <= i_wr_tag;
      r_data[i_wr_idx] <= i_wr_data;
    end
  end

  assign o_rd_hit  = r_valid[i_rd_idx] && (r_tag[i_rd_idx] == i_rd_tag);
  assign o_rd_data = r_data[i_rd_idx];

endmodule

// File: rtl/icache.sv
// Direct-mapped, one-word-per-line instruction cache between fetch and memctrl.
module icache
  import icache_pkg::*;
#(
  parameter int INDEX_BITS = DEF_INDEX_BITS,
  parameter int ADDR_BITS  = DEF_ADDR_BITS
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        clear,
  input  logic        fetch_req,
  input  logic [31:0] fetch_pc,
  output logic        fetch_ready,
  output logic        fetch_valid,
  output logic [31:0] fetch_inst,
  output logic        if_enable,
  output logic [31:0] inst_addr,
  input  logic        if_ready,
  input  logic [31:0] inst
);

  localparam int TAG_BITS = ADDR_BITS - INDEX_BITS - 2;

  icache_state_e r_state;
  logic [31:0]   r_miss_pc;
  logic          r_fetch_valid;
  logic [31:0]   r_fetch_inst;

  logic                  w_hit;
  logic [31:0]           w_rd_data;
  logic                  w_fill;
  logic [INDEX_BITS-1:0] w_rd_idx;
  logic [TAG_BITS-1:0]   w_rd_tag;
  logic [INDEX_BITS-1:0] w_wr_idx;
  logic [TAG_BITS-1:0]   w_wr_tag;
  logic                  w_unused;

  assign w_rd_idx = fetch_pc[INDEX_BITS+1:2];
  assign w_rd_tag = fetch_pc[ADDR_BITS-1:INDEX_BITS+2];
  assign w_wr_idx = r_miss_pc[INDEX_BITS+1:2];
  assign w_wr_tag = r_miss_pc[ADDR_BITS-1:INDEX_BITS+2];
  assign w_unused = ^{fetch_pc[31:ADDR_BITS], fetch_pc[1:0], r_miss_pc[1:0]};

  // A flush in the same cycle as the returning word must not commit the line.
  assign w_fill = rdy_in && !clear && (r_state == ICACHE_REFILL) && if_ready;

  icache_array #(
    .INDEX_BITS (INDEX_BITS),
    .TAG_BITS   (TAG_BITS)
  ) u_array (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .i_wr_en   (w_fill),
    .i_wr_idx  (w_wr_idx),
    .i_wr_tag  (w_wr_tag),
    .i_wr_data (inst),
    .i_rd_idx  (w_rd_idx),
    .i_rd_tag  (w_rd_tag),
    .o_rd_hit  (w_hit),
    .o_rd_data (w_rd_data)
  );

  // Control FSM plus the miss address and the registered fetch response.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state       <= ICACHE_IDLE;
      r_miss_pc     <= 32'h0000_0000;
      r_fetch_valid <= 1'b0;
      r_fetch_inst  <= 32'h0000_0000;
    end else if (rdy_in) begin
      if (clear) begin
        r_state       <= ICACHE_IDLE;
        r_fetch_valid <= 1'b0;
      end else begin
        case (r_state)
          ICACHE_IDLE: begin
            if (fetch_req && w_hit) begin
              r_fetch_valid <= 1'b1;
              r_fetch_inst  <= w_rd_data;
            end else if (fetch_req) begin
              r_miss_pc     <= fetch_pc;
              r_state       <= ICACHE_REFILL;
              r_fetch_valid <= 1'b0;
            end else begin
              r_fetch_valid <= 1'b0;
            end
          end
          ICACHE_REFILL: begin
            if (if_ready) begin
              r_fetch_valid <= 1'b1;
              r_fetch_inst  <= inst;
              r_state       <= ICACHE_IDLE;
            end else begin
              r_fetch_valid <= 1'b0;
            end
          end
          default: begin
            r_state       <= ICACHE_IDLE;
            r_fetch_valid <= 1'b0;
          end
        endcase
      end
    end
  end

  // Request drops in the if_ready cycle so memctrl does not start a second fetch.
  assign if_enable   = (r_state == ICACHE_REFILL) && !if_ready;
  assign inst_addr   = {r_miss_pc[31:2], 2'b00};
  assign fetch_ready = (r_state == ICACHE_IDLE);
  assign fetch_valid = r_fetch_valid;
  assign fetch_inst  = r_fetch_inst;

endmodule

// File: tb/tb_icache.sv
// Directed self-checking bench for icache: miss/refill, hits, aliasing, flush, stall and reset.
module tb_icache;

  logic        clk_in;
  logic        rst_in;
  logic        rdy_in;
  logic        clear;
  logic        fetch_req;
  logic [31:0] fetch_pc;
  logic        fetch_ready;
  logic        fetch_valid;
  logic [31:0] fetch_inst;
  logic        if_enable;
  logic [31:0] inst_addr;
  logic        if_ready;
  logic [31:0] inst;

  int n_checks;
  int n_errors;

  localparam logic [31:0] DATA_A = 32'h0050_0093;
  localparam logic [31:0] DATA_B = 32'h0010_0113;
  localparam logic [31:0] DATA_C = 32'hDEAD_BEEF;
  localparam logic [31:0] DATA_D = 32'h1234_5678;

  icache dut (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .rdy_in      (rdy_in),
    .clear       (clear),
    .fetch_req   (fetch_req),
    .fetch_pc    (fetch_pc),
    .fetch_ready (fetch_ready),
    .fetch_valid (fetch_valid),
    .fetch_inst  (fetch_inst),
    .if_enable   (if_enable),
    .inst_addr   (inst_addr),
    .if_ready    (if_ready),
    .inst        (inst)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  // Full miss: request, wait lat cycles in REFILL, return data, expect the response pulse.
  task automatic do_miss(input string tag, input logic [31:0] pc, input logic [31:0] data,
                         input int lat);
    fetch_req = 1'b1;
    fetch_pc  = pc;
    step();
    check_eq({tag, "_if_en"}, {31'd0, if_enable}, 32'd1);
    check_eq({tag, "_addr"}, inst_addr, {pc[31:2], 2'b00});
    check_eq({tag, "_rdy0"}, {31'd0, fetch_ready}, 32'd0);
    fetch_req = 1'b0;
    for (int i = 0; i < lat; i++) begin
      step();
      check_eq({tag, "_wait_en"}, {31'd0, if_enable}, 32'd1);
    end
    if_ready = 1'b1;
    inst     = data;
    #1;
    check_eq({tag, "_en_drop"}, {31'd0, if_enable}, 32'd0);
    step();
    if_ready = 1'b0;
    inst     = 32'h0000_0000;
    check_eq({tag, "_fv"}, {31'd0, fetch_valid}, 32'd1);
    check_eq({tag, "_inst"}, fetch_inst, data);
    check_eq({tag, "_rdy1"}, {31'd0, fetch_ready}, 32'd1);
  endtask

  // Single-cycle hit: response next cycle with no refill request.
  task automatic do_hit(input string tag, input logic [31:0] pc, input logic [31:0] data);
    fetch_req = 1'b1;
    fetch_pc  = pc;
    step();
    check_eq({tag, "_fv"}, {31'd0, fetch_valid}, 32'd1);
    check_eq({tag, "_inst"}, fetch_inst, data);
    check_eq({tag, "_no_en"}, {31'd0, if_enable}, 32'd0);
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    rst_in    = 1'b1;
    rdy_in    = 1'b1;
    clear     = 1'b0;
    fetch_req = 1'b0;
    fetch_pc  = 32'h0000_0000;
    if_ready  = 1'b0;
    inst      = 32'h0000_0000;
    step();
    step();
    rst_in = 1'b0;
    step();
    check_eq("rst_ready", {31'd0, fetch_ready}, 32'd1);
    check_eq("rst_fv", {31'd0, fetch_valid}, 32'd0);
    check_eq("rst_inst", fetch_inst, 32'd0);
    check_eq("rst_en", {31'd0, if_enable}, 32'd0);
    check_eq("rst_addr", inst_addr, 32'd0);

    // 1: cold miss
    do_miss("cold", 32'h0000_1000, DATA_A, 4);
    step();
    check_eq("cold_pulse_end", {31'd0, fetch_valid}, 32'd0);

    // 2: back-to-back hits
    do_miss("fill1004", 32'h0000_1004, DATA_B, 2);
    do_hit("hit_a1", 32'h0000_1000, DATA_A);
    do_hit("hit_b", 32'h0000_1004, DATA_B);
    do_hit("hit_a2", 32'h0000_1000, DATA_A);
    fetch_req = 1'b0;
    step();
    check_eq("hits_end", {31'd0, fetch_valid}, 32'd0);

    // 3: alias on index 0
    do_miss("alias", 32'h0000_1100, DATA_C, 1);
    do_miss("alias_back", 32'h0000_1000, DATA_A, 1);
    do_hit("alias_rehit", 32'h0000_1000, DATA_A);
    fetch_req = 1'b0;
    step();

    // 4: clear in second refill cycle
    fetch_req = 1'b1;
    fetch_pc  = 32'h0000_2008;
    step();
    fetch_req = 1'b0;
    check_eq("clr_en_before", {31'd0, if_enable}, 32'd1);
    step();
    clear = 1'b1;
    step();
    clear = 1'b0;
    check_eq("clr_en", {31'd0, if_enable}, 32'd0);
    check_eq("clr_ready", {31'd0, fetch_ready}, 32'd1);
    check_eq("clr_fv", {31'd0, fetch_valid}, 32'd0);
    step();
    check_eq("clr_fv2", {31'd0, fetch_valid}, 32'd0);
    do_miss("clr_refetch", 32'h0000_2008, DATA_D, 1);

    // 5: clear together with if_ready
    fetch_req = 1'b1;
    fetch_pc  = 32'h0000_200C;
    step();
    fetch_req = 1'b0;
    step();
    if_ready = 1'b1;
    inst     = DATA_C;
    clear    = 1'b1;
    step();
    if_ready = 1'b0;
    inst     = 32'h0000_0000;
    clear    = 1'b0;
    check_eq("clrrdy_fv", {31'd0, fetch_valid}, 32'd0);
    check_eq("clrrdy_ready", {31'd0, fetch_ready}, 32'd1);
    step();
    check_eq("clrrdy_fv2", {31'd0, fetch_valid}, 32'd0);
    do_miss("clrrdy_refetch", 32'h0000_200C, DATA_B, 1);

    // 6a: stall mid-refill
    fetch_req = 1'b1;
    fetch_pc  = 32'h0000_2010;
    step();
    fetch_req = 1'b0;
    rdy_in    = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("stall_en", {31'd0, if_enable}, 32'd1);
      check_eq("stall_addr", inst_addr, 32'h0000_2010);
      check_eq("stall_ready", {31'd0, fetch_ready}, 32'd0);
      check_eq("stall_fv", {31'd0, fetch_valid}, 32'd0);
    end
    rdy_in   = 1'b1;
    if_ready = 1'b1;
    inst     = DATA_D;
    step();
    if_ready = 1'b0;
    check_eq("stall_fill_fv", {31'd0, fetch_valid}, 32'd1);
    check_eq("stall_fill_inst", fetch_inst, DATA_D);

    // 6b: stall during a hit pulse; a new request must not be taken
    do_hit("stall_hit", 32'h0000_1000, DATA_A);
    rdy_in   = 1'b0;
    fetch_pc = 32'h0000_1004;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("hold_fv", {31'd0, fetch_valid}, 32'd1);
      check_eq("hold_inst", fetch_inst, DATA_A);
    end
    fetch_req = 1'b0;
    rdy_in    = 1'b1;
    step();
    check_eq("hold_release_fv", {31'd0, fetch_valid}, 32'd0);
    check_eq("hold_release_inst", fetch_inst, DATA_A);

    // 6c: async reset mid-refill
    fetch_req = 1'b1;
    fetch_pc  = 32'h0000_3000;
    step();
    fetch_req = 1'b0;
    check_eq("arst_pre_en", {31'd0, if_enable}, 32'd1);
    #2;
    rst_in = 1'b1;
    #1;
    check_eq("arst_ready", {31'd0, fetch_ready}, 32'd1);
    check_eq("arst_en", {31'd0, if_enable}, 32'd0);
    check_eq("arst_inst", fetch_inst, 32'd0);
    check_eq("arst_addr", inst_addr, 32'd0);
    step();
    rst_in = 1'b0;
    step();
    do_miss("arst_refetch", 32'h0000_1000, DATA_C, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
